fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end. Issues one outstanding fetch per cycle pair to instruction memory and pre-decodes each returned word as RV32I or RVC.
- Statically predicts the next fetch PC and buffers fetched instructions in a DEPTH-entry FIFO for the decoder.
- Sits between instruction memory and decode/issue. Execute redirects it on mispredict or indirect-jump resolution.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- RESET_PC, 0, fetch PC after reset.
- BTFN, 1, when 1 conditional branches with negative offset are predicted taken; when 0 all conditional branches are predicted not taken.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall_in  in  1  downstream (LSB/IQ) full; blocks new requests
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  halfword-aligned fetch address
- mem_rsp_valid  in  1  fetch data valid (≥1 cycle after accept)
- mem_rsp_data  in  32  instruction bits at mem_req_addr
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  restart PC
- out_valid  out  1  head entry valid
- out_ready  in  1  decoder consumes head
- out_instr  out  32  instruction; upper 16 bits zero when RVC
- out_pc  out  XLEN  PC of instruction
- out_rvc  out  1  1 = 16-bit instruction
- out_pred_taken  out  1  prediction made
- out_pred_pc  out  XLEN  predicted next PC
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - All outputs 0 except mem_req_addr=RESET_PC.
- State machine: IDLE, WAIT, HALT, DRAIN.
  - IDLE: mem_req_valid = !stall_in && count<DEPTH; mem_req_addr=fetch_pc. On valid&&ready → WAIT.
  - WAIT: mem_req_valid=0. On mem_rsp_valid, push entry, set fetch_pc=predicted PC, → IDLE; or → HALT if the entry is an indirect jump.
  - HALT: no requests until redirect.
  - DRAIN: stale response outstanding. On mem_rsp_valid, discard the data, → IDLE.
- Redirect (highest priority):
  - FIFO cleared; same-cycle pop and push ignored; fetch_pc=redirect_pc.
  - Next state: DRAIN if in WAIT without mem_rsp_valid, or already in DRAIN. Otherwise IDLE.
  - Redirect in IDLE on the same cycle as a request handshake: the request counts as outstanding, → DRAIN.
- FIFO:
  - Space is reserved at issue (count<DEPTH), so a response never overflows.
  - Push and pop in the same cycle leave count unchanged.
  - Head/tail pointers are log2(DEPTH) bits and wrap naturally.
  - out_* show the head combinationally; out_valid = count!=0.
- Pre-decode, with d=mem_rsp_data and pc=fetch_pc:
  - 32-bit (d[1:0]==11):
    - JAL (1101111): taken, target pc+sext(J-imm).
    - BRANCH (1100011): taken iff BTFN && d[31], target pc+sext(B-imm); else pc+4.
    - JALR (1100111): not taken, → HALT.
    - Others, including AUIPC: pc+4.
  - 16-bit: only d[15:0] is used.
    - C.J (op 01, f3 101) and C.JAL (op 01, f3 001): taken, pc+sext(CJ-imm).
    - C.BEQZ/C.BNEZ (op 01, f3 110/111): taken iff BTFN && d[12], pc+sext(CB-imm).
    - C.JR/C.JALR (op 10, f3 100, rs1≠0, rs2=0): → HALT.
    - Others: pc+2.
  - Immediate sign-extension and addition are modulo 2^XLEN. out_pred_pc always holds the computed next PC.

Decomposition:
- Package fetch_pkg:
  - opcode/funct3 constants;
  - state enum;
  - fq_entry_t struct {instr, pc, rvc, pred_taken, pred_pc};
  - imm extraction functions (J, B, CJ, CB).
- Sub-module fetch_predecode: combinational. Inputs d, pc. Outputs rvc, next_pc, pred_taken, halt.

Test Plan:
- Reset, then 0x00000013 (NOP) returned at PC 0 → entry {pc=0, rvc=0, pred_pc=4}; next mem_req_addr=4.
- At PC 0x10, 0x0080006F (JAL +8) → pred_taken=1, pred_pc=0x18; next request address 0x18.
- BTFN=1, at PC 0x40, 0xFE000EE3 (BEQ, offset −4) → pred_taken=1, pred_pc=0x3C. Same case with BTFN=0 → pred_pc=0x44.
- At PC 0x20, 0x00008082 (C.JR ra) → rvc=1, state HALT, no request. Redirect to 0x100 → request 0x100.
- Redirect to 0x200 while WAIT; late response 0x00000013 → discarded, count stays 0, next request 0x200.
- DEPTH=4, out_ready=0, fill 4 NOPs → count=4, mem_req_valid=0. Hold out_ready=1 one cycle → count=3, request resumes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and decode helpers for the instruction-fetch front end.
// Entries carry PCs at the widest supported XLEN; the queue zero-extends on write and truncates on read.
package fetch_pkg;

    localparam int FQ_PC_W = 64;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] C_Q1 = 2'b01;
    localparam logic [1:0] C_Q2 = 2'b10;

    localparam logic [2:0] F3_CJ    = 3'b101;
    localparam logic [2:0] F3_CJAL  = 3'b001;
    localparam logic [2:0] F3_CBEQZ = 3'b110;
    localparam logic [2:0] F3_CBNEZ = 3'b111;
    localparam logic [2:0] F3_CJR   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HALT,
        S_DRAIN
    } fq_state_t;

    typedef struct packed {
        logic [31:0]        instr;
        logic [FQ_PC_W-1:0] pc;
        logic               rvc;
        logic               pred_taken;
        logic [FQ_PC_W-1:0] pred_pc;
    } fq_entry_t;

    // f = instr[31:12]
    function automatic logic [31:0] imm_j(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

    // hi = instr[31:25], lo = instr[11:7]
    function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
        return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction

    // f = c[12:2]
    function automatic logic [31:0] imm_cj(input logic [10:0] f);
        return {{20{f[10]}}, f[10], f[6], f[8:7], f[4], f[5], f[0], f[9], f[3:1], 1'b0};
    endfunction

    // hi = c[12:10], lo = c[6:2]
    function automatic logic [31:0] imm_cb(input logic [2:0] hi, input logic [4:0] lo);
        return {{23{hi[2]}}, hi[2], lo[4:3], lo[0], hi[1:0], lo[2:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of one fetched word: length, static next-PC prediction
// and whether fetch must stop for an indirect jump.
module fetch_predecode
    import fetch_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BTFN = 1
) (
    input  logic [31:0]     d,
    input  logic [XLEN-1:0] pc,
    output logic            rvc,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic            halt
);

    logic [31:0] imm;

    always_comb begin
        rvc        = (d[1:0] != 2'b11);
        imm        = '0;
        pred_taken = 1'b0;
        halt       = 1'b0;
        if (!rvc) begin
            case (d[6:0])
                OP_JAL: begin
                    imm        = imm_j(d[31:12]);
                    pred_taken = 1'b1;
                end
                OP_BRANCH: begin
                    imm        = imm_b(d[31:25], d[11:7]);
                    pred_taken = (BTFN != 0) && d[31];
                end
                OP_JALR: halt = 1'b1;
                default: ;
            endcase
        end else if (d[1:0] == C_Q1) begin
            case (d[15:13])
                F3_CJ, F3_CJAL: begin
                    imm        = imm_cj(d[12:2]);
                    pred_taken = 1'b1;
                end
                F3_CBEQZ, F3_CBNEZ: begin
                    imm        = imm_cb(d[12:10], d[6:2]);
                    pred_taken = (BTFN != 0) && d[12];
                end
                default: ;
            endcase
        end else if (d[1:0] == C_Q2 && d[15:13] == F3_CJR && d[11:7] != 5'd0 && d[6:2] == 5'd0) begin
            halt = 1'b1;
        end

        // Offsets are sign-extended to XLEN so the sum wraps modulo 2^XLEN.
        if (pred_taken) begin
            next_pc = pc + XLEN'($signed(imm));
        end else begin
            next_pc = pc + (rvc ? XLEN'(2) : XLEN'(4));
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding memory request, static next-PC
// prediction and a DEPTH-entry queue feeding decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              BTFN     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_in,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [XLEN-1:0]            mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [31:0]                mem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_rvc,
    output logic                       out_pred_taken,
    output logic [XLEN-1:0]            out_pred_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_state_t       state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PW-1:0]   head_reg, tail_reg;
    logic [CW-1:0]   count_reg;
    fq_entry_t       queue_mem [DEPTH];
    fq_entry_t       head_entry, new_entry;

    logic            pd_rvc, pd_taken, pd_halt;
    logic [XLEN-1:0] pd_next_pc;
    logic            req_fire, push, pop;

    fetch_predecode #(.XLEN(XLEN), .BTFN(BTFN)) u_predecode (
        .d          (mem_rsp_data),
        .pc         (fetch_pc_reg),
        .rvc        (pd_rvc),
        .next_pc    (pd_next_pc),
        .pred_taken (pd_taken),
        .halt       (pd_halt)
    );

    // Request is gated by rst so every output except the address reads zero during reset.
    assign mem_req_valid = rst && (state_reg == S_IDLE) && !stall_in && (count_reg < CW'(DEPTH));
    assign mem_req_addr  = fetch_pc_reg;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign push          = (state_reg == S_WAIT) && mem_rsp_valid && !redirect_valid;
    assign pop           = out_valid && out_ready && !redirect_valid;

    always_comb begin
        new_entry            = '0;
        new_entry.instr      = pd_rvc ? {16'h0000, mem_rsp_data[15:0]} : mem_rsp_data;
        new_entry.pc         = FQ_PC_W'(fetch_pc_reg);
        new_entry.rvc        = pd_rvc;
        new_entry.pred_taken = pd_taken;
        new_entry.pred_pc    = FQ_PC_W'(pd_next_pc);
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            // Any request still in flight must have its response swallowed.
            if ((state_reg == S_WAIT && !mem_rsp_valid) || state_reg == S_DRAIN ||
                (state_reg == S_IDLE && req_fire)) begin
                state_next = S_DRAIN;
            end else begin
                state_next = S_IDLE;
            end
        end else begin
            case (state_reg)
                S_IDLE:  if (req_fire) state_next = S_WAIT;
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        fetch_pc_next = pd_next_pc;
                        state_next    = pd_halt ? S_HALT : S_IDLE;
                    end
                end
                S_HALT:  ;
                S_DRAIN: if (mem_rsp_valid) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if (redirect_valid) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) tail_reg <= tail_reg + PW'(1);
                if (pop)  head_reg <= head_reg + PW'(1);
                if (push && !pop) begin
                    count_reg <= count_reg + CW'(1);
                end else if (pop && !push) begin
                    count_reg <= count_reg - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) queue_mem[tail_reg] <= new_entry;
    end

    assign head_entry     = queue_mem[head_reg];
    assign count          = count_reg;
    assign out_valid      = (count_reg != '0);
    assign out_instr      = out_valid ? head_entry.instr : '0;
    assign out_pc         = out_valid ? head_entry.pc[XLEN-1:0] : '0;
    assign out_rvc        = out_valid && head_entry.rvc;
    assign out_pred_taken = out_valid && head_entry.pred_taken;
    assign out_pred_pc    = out_valid ? head_entry.pred_pc[XLEN-1:0] : '0;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{head_entry.pc, head_entry.pred_pc};

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: two instances (BTFN=1 and BTFN=0) share stimulus
// and are compared each cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        stall_in = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic        redirect_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] mem_rsp_data = '0, redirect_pc = '0;

    logic          req_v [2];
    logic [31:0]   req_addr [2];
    logic          out_v [2];
    logic [31:0]   o_instr [2];
    logic [31:0]   o_pc [2];
    logic          o_rvc [2];
    logic          o_taken [2];
    logic [31:0]   o_pred [2];
    logic [CW-1:0] cnt [2];

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .BTFN(1)) u_btfn (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .mem_req_valid(req_v[0]), .mem_req_ready(mem_req_ready), .mem_req_addr(req_addr[0]),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_v[0]), .out_ready(out_ready), .out_instr(o_instr[0]), .out_pc(o_pc[0]),
        .out_rvc(o_rvc[0]), .out_pred_taken(o_taken[0]), .out_pred_pc(o_pred[0]), .count(cnt[0])
    );

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .BTFN(0)) u_static (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .mem_req_valid(req_v[1]), .mem_req_ready(mem_req_ready), .mem_req_addr(req_addr[1]),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_v[1]), .out_ready(out_ready), .out_instr(o_instr[1]), .out_pc(o_pc[1]),
        .out_rvc(o_rvc[1]), .out_pred_taken(o_taken[1]), .out_pred_pc(o_pred[1]), .count(cnt[1])
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        bit          rvc;
        bit          taken;
        bit          halt;
    } ent_t;

    ent_t        q0[$], q1[$];
    logic [31:0] mpc [2];
    logic [31:0] forced[$];
    logic [31:0] pend;
    bit          outstanding, stale, halted, nop_mode;
    int          cd, lat_cfg;
    int          n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference decode built directly from the ISA encodings.
    function automatic ent_t decode(input logic [31:0] d, input logic [31:0] pc, input bit btfn);
        ent_t        e;
        logic [15:0] c;
        int          off;
        off     = 0;
        e.pc    = pc;
        e.taken = 1'b0;
        e.halt  = 1'b0;
        if (d[1:0] == 2'b11) begin
            e.rvc = 1'b0;
            e.instr = d;
            e.pred_pc = pc + 32'd4;
            if (d[6:0] == 7'h6F) begin
                off = $signed({d[31], d[19:12], d[20], d[30:21], 1'b0});
                e.taken = 1'b1;
            end else if (d[6:0] == 7'h63) begin
                off = $signed({d[31], d[7], d[30:25], d[11:8], 1'b0});
                e.taken = btfn && d[31];
            end else if (d[6:0] == 7'h67) begin
                e.halt = 1'b1;
            end
        end else begin
            c = d[15:0];
            e.rvc = 1'b1;
            e.instr = {16'h0000, c};
            e.pred_pc = pc + 32'd2;
            if (c[1:0] == 2'b01 && (c[15:13] == 3'd5 || c[15:13] == 3'd1)) begin
                off = $signed({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0});
                e.taken = 1'b1;
            end else if (c[1:0] == 2'b01 && c[15:14] == 2'b11) begin
                off = $signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0});
                e.taken = btfn && c[12];
            end else if (c[1:0] == 2'b10 && c[15:13] == 3'd4 && c[11:7] != 5'd0 && c[6:2] == 5'd0) begin
                e.halt = 1'b1;
            end
        end
        if (e.taken) e.pred_pc = pc + off;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 8);
        case (k)
            0: return NOP;
            1: return {r[31:7], 7'h6F};
            2: return {r[31:7], 7'h63};
            3: return {r[31:7], 7'h67};
            4: return {r[31:16], (r[0] ? 3'b101 : 3'b001), r[12:2], 2'b01};
            5: return {r[31:16], 2'b11, r[13], r[12:2], 2'b01};
            6: return {r[31:16], 3'b100, r[12], ((r[11:7] == 5'd0) ? 5'd1 : r[11:7]), 5'd0, 2'b10};
            default: return r;
        endcase
    endfunction

    task automatic start_req();
        if (forced.size() > 0) pend = forced.pop_front();
        else if (nop_mode)     pend = NOP;
        else                   pend = rand_instr();
        cd = (lat_cfg > 0) ? lat_cfg - 1 : $urandom_range(0, 2);
        outstanding = 1'b1;
    endtask

    task automatic check_dut(input int i, input bit exp_rv, input bit has, input ent_t h, input int sz);
        check($sformatf("req_valid[%0d]", i), req_v[i], exp_rv);
        if (exp_rv) check($sformatf("req_addr[%0d]", i), req_addr[i], mpc[i]);
        check($sformatf("out_valid[%0d]", i), out_v[i], has);
        check($sformatf("count[%0d]", i), cnt[i], sz);
        if (has) begin
            check($sformatf("out_instr[%0d]", i), o_instr[i], h.instr);
            check($sformatf("out_pc[%0d]", i), o_pc[i], h.pc);
            check($sformatf("out_rvc[%0d]", i), o_rvc[i], h.rvc);
            check($sformatf("out_taken[%0d]", i), o_taken[i], h.taken);
            check($sformatf("out_pred_pc[%0d]", i), o_pred[i], h.pred_pc);
        end
    endtask

    // One clock: drive inputs after negedge, check, advance the model, wait for next negedge.
    task automatic cycle(input bit stall, input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
        bit   rsp, hs, exp_rv;
        ent_t e0, e1, h;
        rsp = outstanding && cd == 0;
        stall_in = stall; mem_req_ready = rdy; out_ready = ordy;
        redirect_valid = redir; redirect_pc = rpc;
        mem_rsp_valid = rsp;
        mem_rsp_data = rsp ? pend : $urandom();
        #1;
        exp_rv = !outstanding && !halted && !stall && q0.size() < DEPTH;
        h = '{default: '0};
        if (q0.size() > 0) h = q0[0];
        check_dut(0, exp_rv, q0.size() > 0, h, q0.size());
        if (q1.size() > 0) h = q1[0];
        check_dut(1, exp_rv, q1.size() > 0, h, q1.size());

        hs = exp_rv && rdy;
        if (outstanding && !rsp) cd--;
        if (redir) begin
            q0.delete(); q1.delete();
            mpc[0] = rpc; mpc[1] = rpc;
            halted = 1'b0;
            if (rsp) outstanding = 1'b0;
            else if (outstanding) stale = 1'b1;
            if (hs) begin start_req(); stale = 1'b1; end
        end else begin
            if (ordy && q0.size() > 0) begin
                e0 = q0.pop_front();
                void'(q1.pop_front());
                $display("pop pc=%08h instr=%08h pred=%08h taken=%0d", e0.pc, e0.instr, e0.pred_pc, e0.taken);
            end
            if (rsp) begin
                outstanding = 1'b0;
                if (!stale) begin
                    e0 = decode(pend, mpc[0], 1'b1);
                    e1 = decode(pend, mpc[1], 1'b0);
                    q0.push_back(e0); q1.push_back(e1);
                    mpc[0] = e0.pred_pc; mpc[1] = e1.pred_pc;
                    if (e0.halt) halted = 1'b1;
                end
                stale = 1'b0;
            end
            if (hs) begin start_req(); stale = 1'b0; end
        end
        @(negedge clk);
    endtask

    task automatic run_until_push();
        int n;
        for (n = 0; n < 20; n++) begin
            if (q0.size() > 0) break;
            cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        end
        if (n == 20) check("push_timeout", 1, 0);
    endtask

    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
        int n;
        for (n = 0; n < 10 && stale; n++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, pc);
        forced.push_back(data);
        run_until_push();
    endtask

    initial begin
        int n;
        outstanding = 0; stale = 0; halted = 0; nop_mode = 0; cd = 0; lat_cfg = 1;
        mpc[0] = '0; mpc[1] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_req_valid", req_v[i], 0);
            check("rst_req_addr", req_addr[i], 0);
            check("rst_out_valid", out_v[i], 0);
            check("rst_count", cnt[i], 0);
            check("rst_out_instr", o_instr[i], 0);
            check("rst_out_pred_pc", o_pred[i], 0);
        end
        rst = 1'b1;

        forced.push_back(NOP);
        run_until_push();
        check("nop_pc", o_pc[0], 32'h0);
        check("nop_rvc", o_rvc[0], 0);
        check("nop_pred_pc", o_pred[0], 32'h4);
        check("nop_next_addr", req_addr[0], 32'h4);

        fetch_one(32'h10, 32'h0080006F);
        check("jal_taken", o_taken[0], 1);
        check("jal_pred_pc", o_pred[0], 32'h18);
        check("jal_next_addr", req_addr[0], 32'h18);

        fetch_one(32'h40, 32'hFE000EE3);
        check("beq_btfn_taken", o_taken[0], 1);
        check("beq_btfn_pred_pc", o_pred[0], 32'h3C);
        check("beq_static_taken", o_taken[1], 0);
        check("beq_static_pred_pc", o_pred[1], 32'h44);

        fetch_one(32'h20, 32'h00008082);
        check("cjr_rvc", o_rvc[0], 1);
        check("cjr_instr", o_instr[0], 32'h8082);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("halt_no_req", req_v[0], 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        check("halt_redirect_valid", req_v[0], 1);
        check("halt_redirect_addr", req_addr[0], 32'h100);

        lat_cfg = 3;
        forced.push_back(NOP);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        for (n = 0; n < 10 && outstanding; n++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        if (n == 10) check("drain_timeout", 1, 0);
        check("drain_count", cnt[0], 0);
        check("drain_req_valid", req_v[0], 1);
        check("drain_req_addr", req_addr[0], 32'h200);
        lat_cfg = 1;

        nop_mode = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (n = 0; n < 40 && !(q0.size() == DEPTH && !outstanding); n++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        if (n == 40) check("fill_timeout", 1, 0);
        check("full_count", cnt[0], DEPTH);
        check("full_req_valid", req_v[0], 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("pop_count", cnt[0], DEPTH - 1);
        check("pop_req_valid", req_v[0], 1);
        nop_mode = 1'b0;

        lat_cfg = 0;
        for (int k = 0; k < 1500; k++) begin
            bit redir;
            redir = 1'b0;
            if (!stale) redir = halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  redir, $urandom() & 32'hFFFF_FFFE);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
